// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer for the serial ADC reader: fills one bank with 12-bit
// samples while the other bank holds a completed frame for the spectrum stage.
module adc_frame_buffer #(
    parameter int DATA_W     = 12,
    parameter int FRAME_LEN  = 64,
    localparam int ADDR_W    = $clog2(FRAME_LEN),
    parameter int SIGNED_OUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_valid,
    input  logic              frame_done,
    output logic [DATA_W-1:0] frame_peak,
    output logic              overrun,
    output logic [7:0]        drop_count
);

    localparam logic [DATA_W-1:0] MSB_MASK  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] FLIP_MASK = (SIGNED_OUT != 0) ? MSB_MASK : '0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t            state;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] run_peak;
    logic [DATA_W-1:0] peak_next;
    logic              completion;

    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

    // The first sample of a frame loads the peak directly so the previous frame never leaks in.
    always_comb begin
        peak_next = sample_data;
        if (wr_ptr != '0 && run_peak > sample_data)
            peak_next = run_peak;
    end

    assign completion = sample_valid && (wr_ptr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (sample_valid)
            mem[{wr_bank, wr_ptr}] <= sample_data;
    end

    // The read side always sees the bank not being written, so a read on a swap edge returns old data.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= mem[{~wr_bank, rd_addr}] ^ FLIP_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            run_peak    <= '0;
            frame_valid <= 1'b0;
            frame_peak  <= '0;
            overrun     <= 1'b0;
            drop_count  <= '0;
        end else begin
            overrun <= 1'b0;
            if (sample_valid) begin
                wr_ptr   <= wr_ptr + 1'b1;
                run_peak <= peak_next;
            end
            case (state)
                EMPTY: begin
                    if (completion) begin
                        wr_bank     <= ~wr_bank;
                        frame_peak  <= peak_next;
                        frame_valid <= 1'b1;
                        state       <= HELD;
                    end
                end
                HELD: begin
                    if (completion && frame_done) begin
                        wr_bank    <= ~wr_bank;
                        frame_peak <= peak_next;
                    end else if (completion) begin
                        // Consumer still owns the held frame: keep filling the same bank and drop this one.
                        overrun <= 1'b1;
                        if (drop_count != 8'hFF)
                            drop_count <= drop_count + 8'd1;
                    end else if (frame_done) begin
                        frame_valid <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                default: begin
                    frame_valid <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

endmodule
